// File: rtl/shift_reg_if.sv
// Command/data bundle for shift_reg_seq: valid/ready command channel, serial inputs and register outputs.
interface shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, sin_l, sin_r,
    input  cmd_ready, q, sout, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, sin_l, sin_r,
    output cmd_ready, q, sout, done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Sequenced shift register: LOAD, or SHL/SHR/ROT by N steps at one bit per clock, done pulse on completion.
// Optional rotate-left stepping is enabled by defining SHIFT_REG_ROTATE_EN; otherwise ROT completes like amt=0.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  shift_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROT  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  state_e           state;
  state_e           state_nx;
  op_e              cmd_op;
  op_e              op_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] step_q;
  logic             sout_r;
  logic             step_sout;
  logic             done_r;
  logic             accept;
  logic             op_steps;
  logic             starts_shift;
  logic             last_step;

  assign cmd_op        = op_e'(bus.cmd_op);
  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && (state == IDLE);

  // Only these ops walk through SHIFT; a zero count completes immediately like LOAD.
  assign op_steps      = (cmd_op == OP_SHL) || (cmd_op == OP_SHR) ||
                         (ROT_EN && (cmd_op == OP_ROT));
  assign starts_shift  = accept && op_steps && (bus.cmd_amt != '0);
  assign last_step     = (state == SHIFT) && (cnt == AMT_W'(1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (starts_shift) state_nx = SHIFT;
      SHIFT:   if (last_step)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One step of the latched op; serial inputs are sampled live at each step edge.
  always_comb begin
    step_q    = q_r;
    step_sout = sout_r;
    case (op_q)
      OP_SHL: begin
        step_sout = q_r[WIDTH-1];
        step_q    = {q_r[WIDTH-2:0], bus.sin_l};
      end
      OP_SHR: begin
        step_sout = q_r[0];
        step_q    = {bus.sin_r, q_r[WIDTH-1:1]};
      end
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROT: begin
        step_sout = q_r[WIDTH-1];
        step_q    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      sout_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
      op_q   <= OP_LOAD;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          op_q <= cmd_op;
          if (cmd_op == OP_LOAD) begin
            q_r    <= bus.cmd_data;
            done_r <= 1'b1;
          end else if (starts_shift) begin
            cnt <= bus.cmd_amt;
          end else begin
            done_r <= 1'b1;
          end
        end
      end else begin
        q_r    <= step_q;
        sout_r <= step_sout;
        cnt    <= cnt - AMT_W'(1);
        if (last_step) done_r <= 1'b1;
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq (WIDTH=8, AMT_W=4): directed scenarios plus random traffic vs a cycle model.
module tb_shift_reg_seq;
  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_reg_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: register value as an integer, plus how many steps remain.
  int unsigned m_q     = 0;
  int unsigned m_sout  = 0;
  int unsigned m_done  = 0;
  int          m_left  = 0;
  int unsigned m_op    = 0;
  bit          chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q = 0; m_sout = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        if (m_op == 1) begin
          m_sout = m_q / 128;
          m_q    = (m_q * 2 + int'(bus.sin_l)) % 256;
        end else if (m_op == 2) begin
          m_sout = m_q % 2;
          m_q    = m_q / 2 + 128 * int'(bus.sin_r);
        end else begin
          m_sout = m_q / 128;
          m_q    = (m_q * 2 + m_q / 128) % 256;
        end
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (bus.cmd_valid) begin
        if (bus.cmd_op == 2'd0) begin
          m_q    = int'(bus.cmd_data);
          m_done = 1;
        end else if (bus.cmd_amt == 0 || (bus.cmd_op == 2'd3 && !ROT_EN)) begin
          m_done = 1;
        end else begin
          m_left = int'(bus.cmd_amt);
          m_op   = int'(bus.cmd_op);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q",     32'(bus.q),         32'(m_q));
      check("model_sout",  32'(bus.sout),      32'(m_sout));
      check("model_done",  32'(bus.done),      32'(m_done));
      check("model_ready", 32'(bus.cmd_ready), 32'(m_left == 0));
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] amt, input logic [7:0] data);
    @(negedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.cmd_data  = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] q, input logic sout,
                            input logic done, input logic ready);
    check({name, "_q"},     32'(bus.q),         32'(q));
    check({name, "_sout"},  32'(bus.sout),      32'(sout));
    check({name, "_done"},  32'(bus.done),      32'(done));
    check({name, "_ready"}, 32'(bus.cmd_ready), 32'(ready));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_amt   = '0;
    bus.cmd_data  = '0;
    bus.sin_l     = 1'b0;
    bus.sin_r     = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b1);

    // LOAD A5: one-cycle done, ready stays high
    send(2'd0, 4'd0, 8'hA5);
    @(negedge clk); expect_out("load_a5", 8'hA5, 1'b0, 1'b1, 1'b1);
    @(negedge clk); expect_out("load_a5_after", 8'hA5, 1'b0, 1'b0, 1'b1);

    // mid-stream reset held for two cycles
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); expect_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b1);

    // LOAD 81 then SHL 3 with sin_l=1
    send(2'd0, 4'd0, 8'h81);
    @(negedge clk); expect_out("load_81", 8'h81, 1'b0, 1'b1, 1'b1);
    bus.sin_l = 1'b1;
    send(2'd1, 4'd3, 8'h00);
    @(negedge clk); expect_out("shl_e0", 8'h81, 1'b0, 1'b0, 1'b0);
    @(negedge clk); expect_out("shl_e1", 8'h03, 1'b1, 1'b0, 1'b0);
    @(negedge clk); expect_out("shl_e2", 8'h07, 1'b0, 1'b0, 1'b0);
    @(negedge clk); expect_out("shl_e3", 8'h0F, 1'b0, 1'b1, 1'b1);
    @(negedge clk); expect_out("shl_after", 8'h0F, 1'b0, 1'b0, 1'b1);

    // SHR 2 with sin_r=0; a LOAD pulsed while busy must be dropped
    bus.sin_r = 1'b0;
    send(2'd2, 4'd2, 8'h00);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_data = 8'hFF;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    @(negedge clk); expect_out("shr_e1", 8'h07, 1'b1, 1'b0, 1'b0);
    @(negedge clk); expect_out("shr_e2", 8'h03, 1'b1, 1'b1, 1'b1);
    @(negedge clk); expect_out("shr_after", 8'h03, 1'b1, 1'b0, 1'b1);

    // ROT 1 from 81
    send(2'd0, 4'd0, 8'h81);
    send(2'd3, 4'd1, 8'h00);
    @(negedge clk);
    if (ROT_EN) begin
      expect_out("rot_e0", 8'h81, 1'b1, 1'b0, 1'b0);
      @(negedge clk); expect_out("rot_e1", 8'h03, 1'b1, 1'b1, 1'b1);
    end else begin
      expect_out("rot_off", 8'h81, 1'b1, 1'b1, 1'b1);
    end

    // SHL 10 with random sin_l, aborted by reset at the 4th step
    send(2'd1, 4'd10, 8'h00);
    for (int i = 0; i < 3; i++) begin
      bus.sin_l = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); expect_out("abort", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk); expect_out("abort_after", 8'h00, 1'b0, 1'b0, 1'b1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      bus.cmd_valid = ($urandom_range(0, 2) == 0);
      bus.cmd_op    = 2'($urandom);
      bus.cmd_amt   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      bus.cmd_data  = 8'($urandom);
      bus.sin_l     = 1'($urandom);
      bus.sin_r     = 1'($urandom);
      rst           = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst           = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
